// File: rtl/column_approx_div_pkg.sv
// Shared types and constants for the column-truncated approximate divider.
// Feature macro: COLUMN_APPROX_DIV_ROUND_EN (midpoint compensation of truncated columns).
package column_approx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEFAULT_LENGTH = 8;
  localparam int DEFAULT_THETA  = 3;

  // Number of quotient columns actually computed.
  function automatic int iter_count(input int length, input int theta);
    return length - theta;
  endfunction

endpackage

// File: rtl/column_approx_div_if.sv
// Valid/ready operand and result bundle for column_approx_div.
// Feature macro: COLUMN_APPROX_DIV_ROUND_EN (no effect on this interface).
interface column_approx_div_if #(
  parameter int LENGTH = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [2*LENGTH-1:0]   z;
  logic [LENGTH-1:0]     y;
  logic                  out_valid;
  logic                  out_ready;
  logic [LENGTH-1:0]     q;
  logic [LENGTH-1:0]     rem;
  logic                  ovf;
  logic                  dz;

  modport master (
    output in_valid, z, y, out_ready,
    input  in_ready, out_valid, q, rem, ovf, dz
  );

  modport slave (
    input  in_valid, z, y, out_ready,
    output in_ready, out_valid, q, rem, ovf, dz
  );
endinterface

// File: rtl/column_approx_div_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract y.
// Feature macro: COLUMN_APPROX_DIV_ROUND_EN (no effect on this module).
module column_approx_div_step #(
  parameter int LENGTH = 8
) (
  input  logic [LENGTH:0]   i_r,
  input  logic              i_bit,
  input  logic [LENGTH-1:0] i_y,
  output logic [LENGTH:0]   o_r,
  output logic              o_qbit
);

  // Full-width compare keeps every bit of i_r live; R < y bounds the true result.
  always_comb begin
    o_qbit = ({i_r, i_bit} >= {2'b00, i_y});
    o_r    = o_qbit ? (LENGTH+1)'({i_r, i_bit} - {2'b00, i_y})
                    : (LENGTH+1)'({i_r, i_bit});
  end

endmodule

// File: rtl/column_approx_div.sv
// Sequential restoring divider computing only the upper LENGTH-THETA quotient bits.
// Feature macro: COLUMN_APPROX_DIV_ROUND_EN sets q[THETA-1] when the final remainder is non-zero.
module column_approx_div
  import column_approx_pkg::*;
#(
  parameter int LENGTH = DEFAULT_LENGTH,
  parameter int THETA  = DEFAULT_THETA
) (
  input  logic clk,
  input  logic rst,
  column_approx_div_if.slave bus
);

  localparam int ITERS = iter_count(LENGTH, THETA);
  localparam int IW    = (LENGTH > 1) ? $clog2(LENGTH) : 1;
  localparam logic [IW-1:0] FIRST_I = IW'(LENGTH - 1);
  localparam logic [IW-1:0] LAST_I  = IW'(LENGTH - ITERS);

  state_e              r_state;
  state_e              w_state_next;
  logic [LENGTH:0]     r_r;
  logic [LENGTH-1:0]   r_z_lo;
  logic [LENGTH-1:0]   r_y;
  logic [LENGTH-1:0]   r_q;
  logic [LENGTH-1:0]   r_rem;
  logic [IW-1:0]       r_i;
  logic                r_ovf;
  logic                r_dz;

  logic                w_accept;
  logic                w_y_zero;
  logic                w_hi_ovf;
  logic                w_last;
  logic [LENGTH:0]     w_r_next;
  logic                w_qbit;
  logic [LENGTH-1:0]   w_q_step;
  logic [LENGTH-1:0]   w_q_final;

  assign w_accept = (r_state == IDLE) && bus.in_valid;
  assign w_y_zero = (bus.y == '0);
  assign w_hi_ovf = (bus.z[2*LENGTH-1:LENGTH] >= bus.y);
  assign w_last   = (r_i == LAST_I);

  column_approx_div_step #(
    .LENGTH (LENGTH)
  ) u_step (
    .i_r    (r_r),
    .i_bit  (r_z_lo[r_i]),
    .i_y    (r_y),
    .o_r    (w_r_next),
    .o_qbit (w_qbit)
  );

  always_comb begin
    w_q_step      = r_q;
    w_q_step[r_i] = w_qbit;
  end

`ifdef COLUMN_APPROX_DIV_ROUND_EN
  logic [LENGTH-1:0] w_rnd_mask;
  generate
    if (THETA > 0) begin : g_rnd
      assign w_rnd_mask = LENGTH'(1) << (THETA - 1);
    end else begin : g_no_rnd
      assign w_rnd_mask = '0;
    end
  endgenerate
  // Non-zero residue means the true quotient lies above the truncated one.
  assign w_q_final = w_q_step | ((w_r_next != '0) ? w_rnd_mask : '0);
`else
  assign w_q_final = w_q_step;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_next = (w_y_zero || w_hi_ovf) ? DONE : RUN;
        end
      end
      RUN: begin
        if (w_last) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (r_state == IDLE);
    bus.out_valid = (r_state == DONE);
  end

  assign bus.q   = r_q;
  assign bus.rem = r_rem;
  assign bus.ovf = r_ovf;
  assign bus.dz  = r_dz;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_r    <= '0;
      r_z_lo <= '0;
      r_y    <= '0;
      r_q    <= '0;
      r_rem  <= '0;
      r_i    <= '0;
      r_ovf  <= 1'b0;
      r_dz   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_z_lo <= bus.z[LENGTH-1:0];
            r_y    <= bus.y;
            r_i    <= FIRST_I;
            r_r    <= {1'b0, bus.z[2*LENGTH-1:LENGTH]};
            r_rem  <= '0;
            // Divide-by-zero wins over overflow so the flags stay exclusive.
            if (w_y_zero) begin
              r_dz  <= 1'b1;
              r_ovf <= 1'b0;
              r_q   <= '1;
            end else if (w_hi_ovf) begin
              r_dz  <= 1'b0;
              r_ovf <= 1'b1;
              r_q   <= '1;
            end else begin
              r_dz  <= 1'b0;
              r_ovf <= 1'b0;
              r_q   <= '0;
            end
          end
        end
        RUN: begin
          r_r <= w_r_next;
          r_i <= r_i - IW'(1);
          if (w_last) begin
            r_q   <= w_q_final;
            r_rem <= w_r_next[LENGTH-1:0];
          end else begin
            r_q <= w_q_step;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
